// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
`timescale 1ns/1ps
package ifu_pkg;

    typedef enum logic [1:0] {
        AR      = 2'd0,
        R       = 2'd1,
        SEND    = 2'd2,
        WAIT_PC = 2'd3
    } fetch_state_t;

    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [31:0] NOP_FAULT_WORD = 32'h0;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch: one read per instruction, {instruction, pc, fault} handed to decode.
// Latency: zero-wait memory gives decode valid in the 3rd cycle after entering AR.
// Backpressure: holds arvalid until arready, send outputs until ifu_send_ready; one fetch in flight.
`timescale 1ns/1ps
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [XLEN-1:0] pc_next,
    input  logic            pc_next_valid,
    output logic            pc_next_ready,

    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,

    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,

    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc,
    output logic            fetch_fault,
    output logic            ifu_send_valid,
    input  logic            ifu_send_ready
);

    fetch_state_t    state, state_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] instruction_d;
    logic            fetch_fault_d;
    logic            arvalid_d;
    logic            rready_d;
    logic            send_valid_d;
    logic            pc_next_ready_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= AR;
            pc             <= RESET_PC;
            instruction    <= '0;
            fetch_fault    <= 1'b0;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
            ifu_send_valid <= 1'b0;
            pc_next_ready  <= 1'b0;
        end else begin
            state          <= state_d;
            pc             <= pc_d;
            instruction    <= instruction_d;
            fetch_fault    <= fetch_fault_d;
            arvalid        <= arvalid_d;
            rready         <= rready_d;
            ifu_send_valid <= send_valid_d;
            pc_next_ready  <= pc_next_ready_d;
        end
    end

    always_comb begin
        state_d       = state;
        pc_d          = pc;
        instruction_d = instruction;
        fetch_fault_d = fetch_fault;

        case (state)
            AR: begin
                // A misaligned pc never reaches the bus; it is reported as a faulted word.
                if (!is_word_aligned(pc[1:0])) begin
                    state_d       = SEND;
                    instruction_d = NOP_FAULT_WORD;
                    fetch_fault_d = 1'b1;
                end else if (arvalid && arready) begin
                    state_d = R;
                end
            end
            R: begin
                if (rvalid) begin
                    state_d       = SEND;
                    instruction_d = rdata;
                    fetch_fault_d = (rresp != RESP_OKAY);
                end
            end
            SEND: begin
                if (ifu_send_ready) begin
                    state_d = WAIT_PC;
                end
            end
            WAIT_PC: begin
                if (pc_next_valid) begin
                    pc_d    = pc_next;
                    state_d = AR;
                end
            end
            default: state_d = AR;
        endcase

        // Outputs are registered from the next state so they change with the state itself.
        arvalid_d       = (state_d == AR) && is_word_aligned(pc_d[1:0]);
        rready_d        = (state_d == R);
        send_valid_d    = (state_d == SEND);
        pc_next_ready_d = (state_d == WAIT_PC);
    end

    assign araddr = pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios then randomized fetches against a transaction-level model.
`timescale 1ns/1ps
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_next;
    logic        pc_next_valid;
    logic        pc_next_ready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        fetch_fault;
    logic        ifu_send_valid;
    logic        ifu_send_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .pc_next        (pc_next),
        .pc_next_valid  (pc_next_valid),
        .pc_next_ready  (pc_next_ready),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .instruction    (instruction),
        .pc             (pc),
        .fetch_fault    (fetch_fault),
        .ifu_send_valid (ifu_send_valid),
        .ifu_send_ready (ifu_send_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete fetch as decode should see it. Expected word/fault come from the
    // fetch rules: misaligned pc -> zero word with fault, otherwise the memory word
    // with fault set by a non-OKAY response.
    task automatic fetch(input logic [31:0] exp_pc, input int first_wait, input int ar_dly,
                         input int r_dly, input int snd_dly, input logic [31:0] data,
                         input logic [1:0] resp);
        logic        misal;
        logic [31:0] exp_instr;
        logic        exp_fault;
        int          cnt;
        misal     = (exp_pc[1:0] != 2'b00);
        exp_instr = misal ? 32'h0 : data;
        exp_fault = misal || (resp != 2'b00);
        if (snd_dly == 0) ifu_send_ready = 1'b1;
        if (!misal) begin
            cnt = 0;
            while (!arvalid && cnt < 8) begin
                @(negedge clk);
                cnt++;
            end
            chk("ar_wait", cnt, first_wait);
            for (int i = 0; i <= ar_dly; i++) begin
                chk("arvalid_held", {31'b0, arvalid}, 32'd1);
                chk("araddr", araddr, exp_pc);
                arready = (i == ar_dly);
                @(negedge clk);
            end
            arready = 1'b0;
            chk("ar_single", {31'b0, arvalid}, 32'd0);
            rdata = data;
            rresp = resp;
            for (int i = 0; i <= r_dly; i++) begin
                chk("rready", {31'b0, rready}, 32'd1);
                rvalid = (i == r_dly);
                @(negedge clk);
            end
            rvalid = 1'b0;
            rdata  = $urandom;
            rresp  = 2'b00;
        end else begin
            chk("no_ar", {31'b0, arvalid}, 32'd0);
        end
        cnt = 0;
        while (!ifu_send_valid && cnt < 8) begin
            @(negedge clk);
            cnt++;
        end
        chk("send_wait", cnt, misal ? 1 : 0);
        chk("misal_no_ar", {31'b0, arvalid}, 32'd0);
        for (int i = 0; i <= snd_dly; i++) begin
            chk("send_valid", {31'b0, ifu_send_valid}, 32'd1);
            chk("instruction", instruction, exp_instr);
            chk("pc", pc, exp_pc);
            chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, exp_fault});
            ifu_send_ready = (i == snd_dly);
            @(negedge clk);
        end
        ifu_send_ready = 1'b0;
        chk("send_drop", {31'b0, ifu_send_valid}, 32'd0);
        chk("pcn_ready", {31'b0, pc_next_ready}, 32'd1);
    endtask

    task automatic offer_pc(input logic [31:0] v, input int dly);
        for (int i = 0; i < dly; i++) begin
            chk("pcn_hold", {31'b0, pc_next_ready}, 32'd1);
            @(negedge clk);
        end
        pc_next       = v;
        pc_next_valid = 1'b1;
        @(negedge clk);
        pc_next_valid = 1'b0;
        pc_next       = $urandom;
        chk("pcn_taken", {31'b0, pc_next_ready}, 32'd0);
        chk("pc_update", pc, v);
    endtask

    initial begin
        logic [31:0] pcv;
        logic [1:0]  rsp;
        rst            = 1'b0;
        pc_next        = '0;
        pc_next_valid  = 1'b0;
        arready        = 1'b0;
        rdata          = '0;
        rresp          = 2'b00;
        rvalid         = 1'b0;
        ifu_send_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
        chk("rst_rready", {31'b0, rready}, 32'd0);
        chk("rst_send_valid", {31'b0, ifu_send_valid}, 32'd0);
        chk("rst_pcn_ready", {31'b0, pc_next_ready}, 32'd0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
        rst = 1'b1;

        fetch(32'h8000_0000, 1, 0, 0, 0, 32'h0000_0413, 2'b00);
        offer_pc(32'h8000_0004, 0);
        fetch(32'h8000_0004, 0, 4, 0, 1, 32'h1234_5678, 2'b00);
        offer_pc(32'h8000_0102, 1);
        fetch(32'h8000_0102, 0, 0, 0, 3, 32'hAAAA_5555, 2'b00);
        offer_pc(32'h8000_0108, 0);
        fetch(32'h8000_0108, 0, 0, 1, 3, 32'hDEAD_BEEF, 2'b10);
        offer_pc(32'hFFFF_FFFC, 2);
        fetch(32'hFFFF_FFFC, 0, 1, 2, 0, 32'h0badc0de, 2'b00);
        offer_pc(32'h0000_0000, 0);
        fetch(32'h0000_0000, 0, 0, 0, 0, 32'h0000_0013, 2'b00);

        for (int n = 0; n < 24; n++) begin
            pcv = $urandom;
            if ($urandom_range(0, 4) != 0) pcv[1:0] = 2'b00;
            rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            offer_pc(pcv, $urandom_range(0, 2));
            fetch(pcv, 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom, rsp);
        end

        // Reset while a read is outstanding aborts the fetch immediately.
        offer_pc(32'h8000_0200, 0);
        chk("pre_r_arvalid", {31'b0, arvalid}, 32'd1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("in_r_rready", {31'b0, rready}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_arvalid", {31'b0, arvalid}, 32'd0);
        chk("abort_rready", {31'b0, rready}, 32'd0);
        chk("abort_send_valid", {31'b0, ifu_send_valid}, 32'd0);
        chk("abort_pcn_ready", {31'b0, pc_next_ready}, 32'd0);
        chk("abort_pc", pc, 32'h8000_0000);
        @(negedge clk);
        rst = 1'b1;
        fetch(32'h8000_0000, 1, 0, 0, 0, 32'h0000_0493, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
